switch_post_stream: RTL and testbench

- Output-side cell de-framer for a switch egress port, single clock domain.
- Buffers 128-bit (parametrised) cells from the switch core and strips the 2-byte frame header.
- Emits payload as a valid/ready stream of OUT_BYTES-wide beats with byte keep, plus a per-frame descriptor {src_port, payload_len} on its own valid/ready channel.
- Adds malformed-cell discard, resynchronisation on length/last mismatch, and frame/drop statistics.

---
 rtl/switch_post_stream.sv | 260 ++++++++++++++++++++++++++
 tb/tb_switch_post_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_post_stream.sv
`default_nettype none
// ============================================================================
// Module      : switch_post_stream
// Description : Egress cell de-framer. Buffers switch cells in a FWFT FIFO,
//               strips the 2-byte frame header and emits the payload as a
//               valid/ready byte-keep stream plus a per-frame descriptor.
//               Discards malformed cells and resynchronises on last-flag
//               mismatch; keeps saturating frame/drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_post_stream #(
  parameter int CELL_BYTES = 16,
  parameter int OUT_BYTES  = 1,
  parameter int FIFO_DEPTH = 256,
  parameter int BP_THRESH  = 240,
  parameter int MAX_LEN    = 1518
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cell_wr,
  input  logic [CELL_BYTES*8-1:0] cell_din,
  input  logic                    cell_first,
  input  logic                    cell_last,
  output logic                    cell_bp,
  output logic                    out_valid,
  output logic [OUT_BYTES*8-1:0]  out_data,
  output logic [OUT_BYTES-1:0]    out_keep,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    desc_valid,
  output logic [15:0]             desc_data,
  input  logic                    desc_ready,
  output logic                    err_pulse,
  output logic [15:0]             frm_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int c_cw    = CELL_BYTES * 8;
  localparam int c_ow    = OUT_BYTES * 8;
  localparam int c_nb    = CELL_BYTES / OUT_BYTES;
  localparam int c_bw    = (c_nb > 1) ? $clog2(c_nb) : 1;
  localparam int c_aw    = $clog2(FIFO_DEPTH);
  localparam int c_ob_sh = $clog2(OUT_BYTES);
  // First-cell streaming starts at the beat holding byte offset 2.
  localparam logic [c_bw-1:0] c_start_beat = c_bw'(2 / OUT_BYTES);
  localparam logic [c_aw:0]   c_depth      = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_bp_thresh  = (c_aw+1)'(BP_THRESH);
  localparam logic [11:0]     c_max_len    = 12'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  // ---------------- input FIFO ----------------
  logic [c_cw+1:0] mem [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_aw:0]   count_q;
  logic            cell_bp_q;
  logic            push, pop;

  assign push = cell_wr && (count_q != c_depth);

  // Cell storage; occupancy is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {cell_first, cell_last, cell_din};
  end

  // FIFO pointers, occupancy and registered backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cell_bp_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
      count_q   <= count_q + {{c_aw{1'b0}}, push} - {{c_aw{1'b0}}, pop};
      cell_bp_q <= (count_q > c_bp_thresh);
    end
  end

  logic            head_valid, head_first, head_last;
  logic [c_cw-1:0] head_data;
  logic [3:0]      hdr_src;
  logic [11:0]     hdr_len;

  assign head_valid = (count_q != '0);
  assign {head_first, head_last, head_data} = mem[rd_ptr_q];
  assign hdr_src = head_data[c_cw-1 -: 4];
  assign hdr_len = head_data[c_cw-5 -: 12];

  // ---------------- beat selection ----------------
  state_t          state_q, state_d;
  logic [c_bw-1:0] beat_q, beat_d;
  logic [12:0]     rem_q, rem_d;     // frame bytes left from start of current cell
  logic            first_q, first_d; // current cell is the header cell
  logic [15:0]     hdr_q, hdr_d;     // {src_port, payload_len} of frame being streamed

  logic [c_ow-1:0]      beat_slice [c_nb];
  logic [c_ow-1:0]      beat_data;
  logic [OUT_BYTES-1:0] beat_keep;
  logic [12:0]          beat_base, last_idx;
  logic                 final_cell, last_beat, frame_end, can_load, desc_free;

  for (genvar b = 0; b < c_nb; b++) begin : g_beat
    assign beat_slice[b] = head_data[c_cw-1-b*c_ow -: c_ow];
  end

  assign beat_data  = beat_slice[beat_q];
  assign beat_base  = 13'(beat_q) << c_ob_sh;
  assign final_cell = (rem_q <= 13'(CELL_BYTES));
  assign last_idx   = final_cell ? ((rem_q - 13'd1) >> c_ob_sh) : 13'(c_nb - 1);
  assign last_beat  = (13'(beat_q) == last_idx);
  assign frame_end  = final_cell && last_beat;

  // Lane i is kept unless it is header (first cell) or past the frame end.
  for (genvar i = 0; i < OUT_BYTES; i++) begin : g_keep
    logic [12:0] pos;
    assign pos          = beat_base + 13'(i);
    assign beat_keep[i] = (!first_q || (pos >= 13'd2)) && (!final_cell || (pos < rem_q));
  end

  logic            out_valid_q, out_last_q;
  logic [c_ow-1:0] out_data_q;
  logic [OUT_BYTES-1:0] out_keep_q;
  logic            desc_valid_q;
  logic [15:0]     desc_data_q, pend_q;
  logic            err_q, err_d, load, drop_inc, acc_last;
  logic [15:0]     frm_cnt_q, drop_cnt_q;

  assign can_load  = !out_valid_q || out_ready;
  assign desc_free = !desc_valid_q || desc_ready;
  assign acc_last  = out_valid_q && out_ready && out_last_q;

  // Next-state logic: header parse, beat sequencing, cell pops and discards.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rem_d    = rem_q;
    first_d  = first_q;
    hdr_d    = hdr_q;
    pop      = 1'b0;
    load     = 1'b0;
    err_d    = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (head_valid) begin
          if (!head_first) begin
            pop      = 1'b1;
            drop_inc = 1'b1;
          end else if ((hdr_len >= 12'd3) && (hdr_len <= c_max_len)) begin
            hdr_d   = {hdr_src, hdr_len - 12'd2};
            rem_d   = {1'b0, hdr_len};
            first_d = 1'b1;
            beat_d  = c_start_beat;
            state_d = S_STREAM;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_STREAM: begin
        // The closing beat waits for a free descriptor slot.
        if (head_valid && can_load && (!frame_end || desc_free)) begin
          load = 1'b1;
          if (last_beat) begin
            pop     = 1'b1;
            beat_d  = '0;
            first_d = 1'b0;
            rem_d   = rem_q - 13'(CELL_BYTES);
            if (frame_end) begin
              state_d = head_last ? S_IDLE : S_DROP;
              err_d   = !head_last;
            end
          end else begin
            beat_d = beat_q + c_bw'(1);
          end
        end
      end
      S_DROP: begin
        if (head_valid) begin
          pop      = 1'b1;
          drop_inc = 1'b1;
          if (head_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and frame-tracking registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      hdr_q   <= hdr_d;
    end
  end

  // Output beat register, descriptor slot, error pulse and statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      pend_q       <= '0;
      desc_valid_q <= 1'b0;
      desc_data_q  <= '0;
      err_q        <= 1'b0;
      frm_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat_data;
        out_keep_q  <= beat_keep;
        out_last_q  <= frame_end;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Snapshot the descriptor with the closing beat; IDLE may relatch hdr_q early.
      if (load && frame_end) pend_q <= hdr_q;
      if (acc_last) begin
        desc_valid_q <= 1'b1;
        desc_data_q  <= pend_q;
      end else if (desc_ready) begin
        desc_valid_q <= 1'b0;
      end
      err_q <= err_d;
      if (acc_last && (frm_cnt_q != 16'hFFFF)) frm_cnt_q <= frm_cnt_q + 16'd1;
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign cell_bp    = cell_bp_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_last   = out_last_q;
  assign desc_valid = desc_valid_q;
  assign desc_data  = desc_data_q;
  assign err_pulse  = err_q;
  assign frm_cnt    = frm_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_post_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_post_stream
// Description : Self-checking bench for switch_post_stream (16-byte cells,
//               4-byte output beats) against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_post_stream;
  localparam int CB = 16;
  localparam int OB = 4;
  localparam int CW = CB * 8;
  localparam int OW = OB * 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cell_wr = 1'b0;
  logic [CW-1:0] cell_din = '0;
  logic          cell_first = 1'b0;
  logic          cell_last = 1'b0;
  logic          cell_bp;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [OB-1:0] out_keep;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic          desc_valid;
  logic [15:0]   desc_data;
  logic          desc_ready = 1'b1;
  logic          err_pulse;
  logic [15:0]   frm_cnt;
  logic [15:0]   drop_cnt;

  switch_post_stream #(
    .CELL_BYTES(CB), .OUT_BYTES(OB), .FIFO_DEPTH(256), .BP_THRESH(240), .MAX_LEN(1518)
  ) dut (
    .clk(clk), .rstn(rstn), .cell_wr(cell_wr), .cell_din(cell_din),
    .cell_first(cell_first), .cell_last(cell_last), .cell_bp(cell_bp),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .out_ready(out_ready), .desc_valid(desc_valid),
    .desc_data(desc_data), .desc_ready(desc_ready), .err_pulse(err_pulse),
    .frm_cnt(frm_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [OW-1:0] data; logic [OB-1:0] keep; logic last; } beat_t;
  typedef struct { logic [CW-1:0] data; logic first; logic last; } cell_t;

  beat_t       exp_beats[$];
  logic [15:0] exp_desc[$];
  cell_t       tx[$];
  int checks = 0, errors = 0;
  int exp_frm = 0, exp_drop = 0, exp_err = 0, obs_err = 0;
  bit chk_bubble = 1'b1, rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole frame as a byte array; beats are the aligned
  // OB-byte windows of the frame that hold any payload byte (offsets 2..len-1).
  task automatic add_frame(input int src, input int len, input bit bad_last);
    byte unsigned fb[];
    int    nc;
    cell_t cl;
    beat_t b;
    nc = (len + CB - 1) / CB;
    fb = new[nc * CB];
    foreach (fb[i]) fb[i] = 8'($urandom);
    fb[0] = {src[3:0], len[11:8]};
    fb[1] = len[7:0];
    for (int c = 0; c < nc; c++) begin
      cl.first = (c == 0);
      cl.last  = (c == nc - 1) && !bad_last;
      for (int j = 0; j < CB; j++) cl.data[CW-1-8*j -: 8] = fb[c*CB + j];
      tx.push_back(cl);
    end
    if (bad_last) begin
      cl.first = 1'b0; cl.last = 1'b1; cl.data = CW'($urandom);
      tx.push_back(cl);
      exp_drop++;
      exp_err++;
    end
    for (int k = 2 / OB; k <= (len - 1) / OB; k++) begin
      b.data = '0; b.keep = '0;
      for (int i = 0; i < OB; i++) begin
        if ((k*OB + i >= 2) && (k*OB + i < len)) begin
          b.keep[i] = 1'b1;
          b.data[OW-1-8*i -: 8] = fb[k*OB + i];
        end
      end
      b.last = (k == (len - 1) / OB);
      exp_beats.push_back(b);
    end
    exp_desc.push_back({src[3:0], 12'(len - 2)});
    exp_frm++;
  endtask

  // A single discarded cell: orphan (first=0) or header with illegal length.
  task automatic add_junk(input bit first, input int len);
    cell_t cl;
    cl.data = {CW{1'b0}} | CW'($urandom);
    cl.data[CW-1 -: 16] = {4'h1, 12'(len)};
    cl.first = first; cl.last = 1'b1;
    tx.push_back(cl);
    exp_drop++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_cell(input cell_t c);
    cell_wr = 1'b1; cell_din = c.data; cell_first = c.first; cell_last = c.last;
    tick();
    cell_wr = 1'b0;
  endtask

  task automatic send_all();
    while (tx.size() != 0) send_cell(tx.pop_front());
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_desc.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(tag, 64'(exp_beats.size() + exp_desc.size()), 64'(0));
  endtask

  // Output monitor: beat/descriptor scoreboard, stall stability, bubbles.
  initial begin
    beat_t         e;
    logic [OW-1:0] m;
    logic [OW-1:0] h_data;
    logic [OB-1:0] h_keep;
    logic          h_last;
    bit            h_pend = 1'b0, prev_nonlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (h_pend)
          chk("stall_hold", 64'({out_valid, out_last, out_keep, out_data}),
              64'({1'b1, h_last, h_keep, h_data}));
        if (chk_bubble && prev_nonlast) chk("bubble", 64'(out_valid), 64'(1));
        h_pend = out_valid && !out_ready;
        h_data = out_data; h_keep = out_keep; h_last = out_last;
        prev_nonlast = out_valid && out_ready && !out_last;
        if (out_valid && out_ready) begin
          chk("beat_avail", 64'(exp_beats.size() != 0), 64'(1));
          if (exp_beats.size() != 0) begin
            e = exp_beats.pop_front();
            for (int i = 0; i < OB; i++) m[OW-1-8*i -: 8] = {8{e.keep[i]}};
            chk("beat", 64'({out_last, out_keep, out_data & m}), 64'({e.last, e.keep, e.data}));
          end
        end
        if (desc_valid && desc_ready) begin
          chk("desc_avail", 64'(exp_desc.size() != 0), 64'(1));
          if (exp_desc.size() != 0) chk("desc", 64'(desc_data), 64'(exp_desc.pop_front()));
        end
        if (err_pulse) obs_err++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'({out_data, out_keep, out_last}), 64'(0));
    chk("rst_desc", 64'({desc_valid, desc_data}), 64'(0));
    chk("rst_misc", 64'({cell_bp, err_pulse}), 64'(0));
    chk("rst_cnts", 64'({frm_cnt, drop_cnt}), 64'(0));
    rstn = 1'b1;
    repeat (2) tick();

    // Frame len 62, port 5, four cells; first-cell latency
    add_frame(5, 62, 1'b0);
    send_cell(tx.pop_front());
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("latency", 64'(seen), 64'(1));
    send_all();
    drain("t1_drain", 500);
    chk("t1_frm", 64'(frm_cnt), 64'(exp_frm));

    // len 32, two cells
    add_frame(2, 32, 1'b0);
    send_all();
    drain("t2_drain", 500);

    // Three back-to-back random frames with random out_ready
    rand_rdy = 1'b1;
    repeat (3) add_frame(int'($urandom_range(0, 15)), int'($urandom_range(3, 120)), 1'b0);
    send_all();
    drain("t3_drain", 2000);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    tick();

    // Orphan, length boundaries, illegal lengths
    add_junk(1'b0, 40);
    add_frame(3, 3, 1'b0);
    add_junk(1'b1, 2);
    add_junk(1'b1, 1519);
    add_frame(7, 1518, 1'b0);
    add_frame(11, 50, 1'b0);
    send_all();
    drain("t4_drain", 3000);
    chk("t4_drop", 64'(drop_cnt), 64'(exp_drop));

    // Last-flag mismatch on final cell, then a good frame
    add_frame(4, 34, 1'b1);
    add_frame(6, 45, 1'b0);
    send_all();
    drain("t5_drain", 500);
    chk("t5_err", 64'(obs_err), 64'(exp_err));
    chk("t5_drop", 64'(drop_cnt), 64'(exp_drop));
    chk("t5_frm", 64'(frm_cnt), 64'(exp_frm));

    // Backpressure threshold
    out_ready = 1'b0;
    repeat (242) add_frame(int'($urandom_range(0, 15)), 16, 1'b0);
    repeat (240) send_cell(tx.pop_front());
    tick();
    chk("bp_at_240", 64'(cell_bp), 64'(0));
    send_cell(tx.pop_front());
    chk("bp_latency", 64'(cell_bp), 64'(0));
    tick();
    chk("bp_at_241", 64'(cell_bp), 64'(1));
    send_cell(tx.pop_front());
    out_ready = 1'b1;
    for (int n = 0; n < 500 && cell_bp; n++) tick();
    chk("bp_release", 64'(cell_bp), 64'(0));
    drain("t6_drain", 4000);

    // Descriptor slot full withholds the next closing beat
    chk_bubble = 1'b0;
    desc_ready = 1'b0;
    add_frame(2, 20, 1'b0);
    add_frame(9, 40, 1'b0);
    send_all();
    repeat (60) tick();
    chk("dstall_beats_left", 64'(exp_beats.size()), 64'(1));
    chk("dstall_out_valid", 64'(out_valid), 64'(0));
    chk("dstall_desc_valid", 64'(desc_valid), 64'(1));
    desc_ready = 1'b1;
    drain("t7_drain", 500);
    chk_bubble = 1'b1;

    chk("end_frm", 64'(frm_cnt), 64'(exp_frm));
    chk("end_drop", 64'(drop_cnt), 64'(exp_drop));
    chk("end_err", 64'(obs_err), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
